alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Multi-cycle instruction sequencer that drives the 32-bit ALU from the opposite side of its Select/operand/flag interface. It accepts 16-bit instruction words over a valid/ready handshake and decodes the 5-bit opcode into the ALU Select code. It fetches operands from an internal 8x32 register file, captures the ALU Result and Z/N/C/V flags, and writes back. It sits between the instruction source and the combinational ALU.

## Interface
- NUM_REGS, 8, register file depth (fixed; address width 3)
- DATA_W, 32, datapath width (matches ALU)
- Clk  in  1  rising-edge clock
- Rst_n  in  1  asynchronous, active-low reset
- Instr  in  16  instruction word, sampled on accept
- Instr_Valid  in  1  instruction source has a word
- Instr_Ready  out  1  sequencer can accept (high only in IDLE)
- Alu_Select  out  5  opcode to ALU
- Alu_In_1  out  32  ALU operand 1
- Alu_In_2  out  32  ALU operand 2
- Alu_Result  in  32  ALU output (combinational from Alu_In_*/Alu_Select)
- Alu_Z, Alu_N, Alu_C, Alu_V  in  1 each  ALU flags
- Flags  out  4  registered {Z,N,C,V} of last legal instruction
- Done  out  1  one-cycle pulse, legal instruction retired
- Err  out  1  one-cycle pulse, illegal opcode retired
- Dbg_Addr  in  3  debug register read address
- Dbg_Data  out  32  combinational read of register Dbg_Addr

## Operation
- Instruction format: Instr[15:11] opcode, [10:8] rd, [7:5] rs1, [4:2] rs2, [1:0] reserved (ignored).
- LD (0x01): Alu_In_1 = zero-extended Instr[7:0]; Alu_In_2 = 0; the rs1/rs2 fields are not used.
- ADD 0x03, SUB 0x04, AND 0x05, OR 0x06, XOR 0x07: In_1 = R[rs1], In_2 = R[rs2].
- NOT 0x08, SL 0x09, SR 0x0A: In_1 = R[rs1], In_2 = 0.
- Illegal opcodes are 0x00, 0x02 and 0x0B–0x1F. They do not write back, do not update Flags, and assert Err instead of Done. Alu_Select is still driven with the raw opcode.
- FSM states and transitions:
  - IDLE: Instr_Ready=1. Instr_Valid=1 latches Instr and moves to DECODE.
  - DECODE: latch operands from the register file; classify the opcode as legal or illegal. Next state EXEC.
  - EXEC: Alu_Select and Alu_In_* are held stable from registered values. Alu_Result and flags are captured at the end of the cycle. Next state WB.
  - WB: a legal opcode writes R[rd] and updates Flags, with Done=1. An illegal opcode gives Err=1. Next state IDLE.
- rd may equal rs1/rs2. Operands are latched in DECODE, so the old value is used.
- Alu_Select/Alu_In_* hold their last values outside EXEC and are 0 after reset.
- Dbg_Data reflects the write on the cycle after the WB edge.

## Timing
- Reset values: all 32-bit registers R0–R7 = 0, Flags = 0, Instr_Ready = 1 (IDLE), Done = 0, Err = 0, Alu_Select = 0, Alu_In_1 = 0, Alu_In_2 = 0.
- Accept at edge T when Instr_Valid & Instr_Ready. DECODE runs T+1, EXEC T+2, and WB T+3, with Done/Err high during the T+3 cycle. Instr_Ready returns high at T+4.
- Fixed latency of 4 cycles and throughput of 1 instruction per 4 cycles. There are no back-to-back accepts.
- Instr_Valid is ignored outside IDLE. The instruction source must hold Instr until accepted.
- Asserting Rst_n low mid-instruction aborts immediately to IDLE. No write back occurs, and no Done/Err pulse is produced.
- Arithmetic wraps modulo 2^32, as produced by the ALU. The sequencer performs no arithmetic itself.

## Structure
- Shared package holds:
  - opcode localparams (OP_LD, OP_ADD, … OP_SR)
  - state encoding (IDLE, DECODE, EXEC, WB)
  - instruction field positions
- One sub-module, alu_regfile: 8x32 storage with two read ports (rs1, rs2), one combinational debug read port, one write port, and async active-low clear.
- The ALU is instantiated by the bench/top level, not inside this block.

## Test plan
- Reset, then LD R1 with imm 0x05 -> Done pulses at T+3; Dbg_Data(R1) = 0x00000005; Instr_Ready low for T+1..T+3.
- LD R1=5 and LD R2=3, then ADD R3,R1,R2 -> R3 = 0x00000008; Flags Z=0. SUB R4,R1,R1 -> R4 = 0; Flags Z=1.
- R1=0x0F and R2=0xF0: OR R5 -> 0xFF; XOR R6,R5,R1 -> 0xF0; NOT R7,R1 -> 0xFFFFFFF0; SL R1 -> 0x1E; SR R2 -> 0x78.
- Opcode 0x02 with rd=R3 and prior Flags=Z -> Err pulses at T+3, no Done; R3 and Flags are unchanged.
- ADD R1,R1,R1 with R1=4 -> R1 = 8, which confirms the old-value operand latch.
- Hold Instr_Valid high continuously -> accepts occur exactly every 4 cycles. Assert Rst_n low during EXEC -> all registers read 0, no Done, and Instr_Ready = 1 after release.

Source files
------------

// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU instruction sequencer: opcodes, FSM states,
// instruction field positions and opcode classification helpers.
package alu_op_sequencer_pkg;

  localparam logic [4:0] OP_LD  = 5'h01;
  localparam logic [4:0] OP_ADD = 5'h03;
  localparam logic [4:0] OP_SUB = 5'h04;
  localparam logic [4:0] OP_AND = 5'h05;
  localparam logic [4:0] OP_OR  = 5'h06;
  localparam logic [4:0] OP_XOR = 5'h07;
  localparam logic [4:0] OP_NOT = 5'h08;
  localparam logic [4:0] OP_SL  = 5'h09;
  localparam logic [4:0] OP_SR  = 5'h0A;

  localparam int INSTR_W = 16;
  localparam int REG_AW  = 3;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 11;
  localparam int RD_HI  = 10;
  localparam int RD_LO  = 8;
  localparam int RS1_HI = 7;
  localparam int RS1_LO = 5;
  localparam int RS2_HI = 4;
  localparam int RS2_LO = 2;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_WB     = 2'd3
  } state_t;

  function automatic logic op_is_legal(input logic [4:0] op);
    return (op == OP_LD) || ((op >= OP_ADD) && (op <= OP_SR));
  endfunction

  // Two-operand ops read R[rs2]; unary ops and LD drive operand 2 with zero.
  function automatic logic op_uses_rs2(input logic [4:0] op);
    return (op >= OP_ADD) && (op <= OP_XOR);
  endfunction

endpackage

// File: rtl/alu_op_sequencer_regfile.sv
// 8x32 register file: two combinational read ports, one debug read port,
// one synchronous write port, asynchronous active-low clear.
module alu_regfile
  import alu_op_sequencer_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [REG_AW-1:0] i_raddr1,
  input  logic [REG_AW-1:0] i_raddr2,
  input  logic [REG_AW-1:0] i_dbg_addr,
  output logic [DATA_W-1:0] o_rdata1,
  output logic [DATA_W-1:0] o_rdata2,
  output logic [DATA_W-1:0] o_dbg_data
);

  logic [DATA_W-1:0] r_mem [NUM_REGS];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1   = r_mem[i_raddr1];
  assign o_rdata2   = r_mem[i_raddr2];
  assign o_dbg_data = r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_op_sequencer.sv
// Four-state instruction sequencer (IDLE/DECODE/EXEC/WB) that feeds an external
// combinational ALU from an internal register file and writes results back.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int DATA_W   = 32
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic [INSTR_W-1:0]  Instr,
  input  logic                Instr_Valid,
  output logic                Instr_Ready,
  output logic [4:0]          Alu_Select,
  output logic [DATA_W-1:0]   Alu_In_1,
  output logic [DATA_W-1:0]   Alu_In_2,
  input  logic [DATA_W-1:0]   Alu_Result,
  input  logic                Alu_Z,
  input  logic                Alu_N,
  input  logic                Alu_C,
  input  logic                Alu_V,
  output logic [3:0]          Flags,
  output logic                Done,
  output logic                Err,
  input  logic [REG_AW-1:0]   Dbg_Addr,
  output logic [DATA_W-1:0]   Dbg_Data
);

  state_t              r_state;
  state_t              w_next;
  logic [INSTR_W-1:0]  r_instr;
  logic                r_legal;
  logic [4:0]          r_alu_sel;
  logic [DATA_W-1:0]   r_in1;
  logic [DATA_W-1:0]   r_in2;
  logic [DATA_W-1:0]   r_result;
  logic [3:0]          r_flag_cap;
  logic [3:0]          r_flags;

  logic [4:0]          w_opc;
  logic [REG_AW-1:0]   w_rd;
  logic [REG_AW-1:0]   w_rs1;
  logic [REG_AW-1:0]   w_rs2;
  logic [DATA_W-1:0]   w_rdata1;
  logic [DATA_W-1:0]   w_rdata2;
  logic [DATA_W-1:0]   w_imm;
  logic                w_we;
  logic                w_accept;
  logic                w_unused_rsvd;

  assign w_opc  = r_instr[OPC_HI:OPC_LO];
  assign w_rd   = r_instr[RD_HI:RD_LO];
  assign w_rs1  = r_instr[RS1_HI:RS1_LO];
  assign w_rs2  = r_instr[RS2_HI:RS2_LO];
  assign w_imm  = {{(DATA_W-8){1'b0}}, r_instr[IMM_HI:IMM_LO]};
  assign w_unused_rsvd = ^r_instr[1:0];

  assign w_accept = (r_state == ST_IDLE) && Instr_Valid;
  assign w_we     = (r_state == ST_WB) && r_legal;

  alu_regfile #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .i_clk      (Clk),
    .i_rst_n    (Rst_n),
    .i_we       (w_we),
    .i_waddr    (w_rd),
    .i_wdata    (r_result),
    .i_raddr1   (w_rs1),
    .i_raddr2   (w_rs2),
    .i_dbg_addr (Dbg_Addr),
    .o_rdata1   (w_rdata1),
    .o_rdata2   (w_rdata2),
    .o_dbg_data (Dbg_Data)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (Instr_Valid) w_next = ST_DECODE;
      ST_DECODE: w_next = ST_EXEC;
      ST_EXEC:   w_next = ST_WB;
      ST_WB:     w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Instruction word and ALU capture carry no reset; the state machine gates their use.
  always_ff @(posedge Clk) begin
    if (w_accept) r_instr <= Instr;
    if (r_state == ST_EXEC) begin
      r_result   <= Alu_Result;
      r_flag_cap <= {Alu_Z, Alu_N, Alu_C, Alu_V};
    end
  end

  // Operands are latched at the end of DECODE, so rd==rs reads the pre-write value.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_legal   <= 1'b0;
      r_alu_sel <= '0;
      r_in1     <= '0;
      r_in2     <= '0;
      r_flags   <= '0;
    end else begin
      if (r_state == ST_DECODE) begin
        r_legal   <= op_is_legal(w_opc);
        r_alu_sel <= w_opc;
        r_in1     <= (w_opc == OP_LD) ? w_imm : w_rdata1;
        r_in2     <= op_uses_rs2(w_opc) ? w_rdata2 : '0;
      end
      if (w_we) r_flags <= r_flag_cap;
    end
  end

  assign Instr_Ready = (r_state == ST_IDLE);
  assign Alu_Select  = r_alu_sel;
  assign Alu_In_1    = r_in1;
  assign Alu_In_2    = r_in2;
  assign Flags       = r_flags;
  assign Done        = (r_state == ST_WB) && r_legal;
  assign Err         = (r_state == ST_WB) && !r_legal;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural 32-bit ALU attached.
module tb_alu_op_sequencer;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic [15:0] Instr = '0;
  logic        Instr_Valid = 1'b0;
  logic        Instr_Ready;
  logic [4:0]  Alu_Select;
  logic [31:0] Alu_In_1, Alu_In_2, Alu_Result;
  logic        Alu_Z, Alu_N, Alu_C, Alu_V;
  logic [3:0]  Flags;
  logic        Done, Err;
  logic [2:0]  Dbg_Addr = '0;
  logic [31:0] Dbg_Data;

  int checks = 0;
  int failures = 0;
  logic [31:0] ex_in1, ex_in2, rd_val;

  always #5 Clk = ~Clk;

  alu_op_sequencer dut (
    .Clk(Clk), .Rst_n(Rst_n), .Instr(Instr), .Instr_Valid(Instr_Valid),
    .Instr_Ready(Instr_Ready), .Alu_Select(Alu_Select), .Alu_In_1(Alu_In_1),
    .Alu_In_2(Alu_In_2), .Alu_Result(Alu_Result), .Alu_Z(Alu_Z), .Alu_N(Alu_N),
    .Alu_C(Alu_C), .Alu_V(Alu_V), .Flags(Flags), .Done(Done), .Err(Err),
    .Dbg_Addr(Dbg_Addr), .Dbg_Data(Dbg_Data)
  );

  // Reference ALU: LD passes In_1, C is carry (ADD), borrow (SUB) or shifted-out bit.
  always_comb begin
    Alu_Result = '0;
    Alu_C = 1'b0;
    Alu_V = 1'b0;
    case (Alu_Select)
      5'h01: Alu_Result = Alu_In_1;
      5'h03: begin
        {Alu_C, Alu_Result} = {1'b0, Alu_In_1} + {1'b0, Alu_In_2};
        Alu_V = (Alu_In_1[31] == Alu_In_2[31]) && (Alu_Result[31] != Alu_In_1[31]);
      end
      5'h04: begin
        Alu_Result = Alu_In_1 - Alu_In_2;
        Alu_C = Alu_In_1 < Alu_In_2;
        Alu_V = (Alu_In_1[31] != Alu_In_2[31]) && (Alu_Result[31] != Alu_In_1[31]);
      end
      5'h05: Alu_Result = Alu_In_1 & Alu_In_2;
      5'h06: Alu_Result = Alu_In_1 | Alu_In_2;
      5'h07: Alu_Result = Alu_In_1 ^ Alu_In_2;
      5'h08: Alu_Result = ~Alu_In_1;
      5'h09: begin Alu_Result = Alu_In_1 << 1; Alu_C = Alu_In_1[31]; end
      5'h0A: begin Alu_Result = Alu_In_1 >> 1; Alu_C = Alu_In_1[0]; end
      default: Alu_Result = '0;
    endcase
  end
  assign Alu_Z = (Alu_Result == '0);
  assign Alu_N = Alu_Result[31];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic rd_reg(input logic [2:0] a, output logic [31:0] v);
    Dbg_Addr = a;
    #1;
    v = Dbg_Data;
  endtask

  // Issues one instruction from IDLE and checks the 4-cycle handshake/pulse timeline.
  task automatic run_instr(input string tag, input logic [15:0] ins, input logic legal);
    chk({tag, ".rdy_idle"}, 32'(Instr_Ready), 32'd1);
    Instr = ins;
    Instr_Valid = 1'b1;
    @(posedge Clk); #1;
    Instr_Valid = 1'b0;
    chk({tag, ".rdy_dec"}, 32'(Instr_Ready), 32'd0);
    chk({tag, ".pulse_dec"}, 32'({Done, Err}), 32'd0);
    @(posedge Clk); #1;
    chk({tag, ".rdy_exec"}, 32'(Instr_Ready), 32'd0);
    chk({tag, ".sel_exec"}, 32'(Alu_Select), 32'(ins[15:11]));
    ex_in1 = Alu_In_1;
    ex_in2 = Alu_In_2;
    @(posedge Clk); #1;
    chk({tag, ".rdy_wb"}, 32'(Instr_Ready), 32'd0);
    chk({tag, ".done_wb"}, 32'(Done), 32'(legal));
    chk({tag, ".err_wb"}, 32'(Err), 32'(!legal));
    @(posedge Clk); #1;
    chk({tag, ".rdy_back"}, 32'(Instr_Ready), 32'd1);
    chk({tag, ".pulse_back"}, 32'({Done, Err}), 32'd0);
  endtask

  initial begin
    logic [15:0] ready_mask;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst.rdy", 32'(Instr_Ready), 32'd1);
    chk("rst.done", 32'(Done), 32'd0);
    chk("rst.err", 32'(Err), 32'd0);
    chk("rst.flags", 32'(Flags), 32'd0);
    chk("rst.sel", 32'(Alu_Select), 32'd0);
    chk("rst.in1", Alu_In_1, 32'd0);
    chk("rst.in2", Alu_In_2, 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(posedge Clk); #1;
    rd_reg(3'd7, rd_val); chk("rst.r7", rd_val, 32'd0);

    run_instr("ld_r1", 16'h0905, 1'b1);
    chk("ld_r1.in1", ex_in1, 32'h5);
    chk("ld_r1.in2", ex_in2, 32'h0);
    rd_reg(3'd1, rd_val); chk("ld_r1.val", rd_val, 32'h5);
    run_instr("ld_r2", 16'h0A03, 1'b1);
    run_instr("add_r3", 16'h1B28, 1'b1);
    chk("add_r3.in1", ex_in1, 32'h5);
    chk("add_r3.in2", ex_in2, 32'h3);
    rd_reg(3'd3, rd_val); chk("add_r3.val", rd_val, 32'h8);
    chk("add_r3.flags", 32'(Flags), 32'h0);
    chk("add_r3.sel_hold", 32'(Alu_Select), 32'h03);
    run_instr("sub_r4", 16'h2424, 1'b1);
    rd_reg(3'd4, rd_val); chk("sub_r4.val", rd_val, 32'h0);
    chk("sub_r4.flags", 32'(Flags), 32'h8);

    run_instr("ill_02", 16'h1328, 1'b0);
    rd_reg(3'd3, rd_val); chk("ill_02.r3", rd_val, 32'h8);
    chk("ill_02.flags", 32'(Flags), 32'h8);
    run_instr("ill_1f", 16'hF800, 1'b0);
    rd_reg(3'd0, rd_val); chk("ill_1f.r0", rd_val, 32'h0);

    run_instr("ld_r1b", 16'h090F, 1'b1);
    run_instr("ld_r2b", 16'h0AF0, 1'b1);
    run_instr("or_r5", 16'h3528, 1'b1);
    rd_reg(3'd5, rd_val); chk("or_r5.val", rd_val, 32'hFF);
    run_instr("xor_r6", 16'h3EA4, 1'b1);
    rd_reg(3'd6, rd_val); chk("xor_r6.val", rd_val, 32'hF0);
    run_instr("not_r7", 16'h4720, 1'b1);
    chk("not_r7.in2", ex_in2, 32'h0);
    rd_reg(3'd7, rd_val); chk("not_r7.val", rd_val, 32'hFFFFFFF0);
    chk("not_r7.flags", 32'(Flags), 32'h4);
    run_instr("sl_r1", 16'h4920, 1'b1);
    rd_reg(3'd1, rd_val); chk("sl_r1.val", rd_val, 32'h1E);
    run_instr("sr_r2", 16'h5240, 1'b1);
    rd_reg(3'd2, rd_val); chk("sr_r2.val", rd_val, 32'h78);
    chk("sr_r2.flags", 32'(Flags), 32'h0);

    run_instr("ld_r1c", 16'h0904, 1'b1);
    run_instr("add_self", 16'h1924, 1'b1);
    rd_reg(3'd1, rd_val); chk("add_self.val", rd_val, 32'h8);

    // Instr_Valid held high: ready should be seen on every fourth falling edge.
    ready_mask = '0;
    Instr = 16'h0877;
    Instr_Valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge Clk);
      ready_mask[i] = Instr_Ready;
      if (i == 15) Instr_Valid = 1'b0;
    end
    @(posedge Clk); #1;
    chk("stream.mask", 32'(ready_mask), 32'h1111);
    rd_reg(3'd0, rd_val); chk("stream.r0", rd_val, 32'h77);

    // Reset asserted during EXEC of an LD to R1.
    Instr = 16'h0909;
    Instr_Valid = 1'b1;
    @(posedge Clk); #1;
    Instr_Valid = 1'b0;
    @(posedge Clk); #1;
    chk("abort.sel_exec", 32'(Alu_Select), 32'h01);
    Rst_n = 1'b0;
    #1;
    chk("abort.rdy", 32'(Instr_Ready), 32'd1);
    chk("abort.pulse", 32'({Done, Err}), 32'd0);
    chk("abort.flags", 32'(Flags), 32'd0);
    chk("abort.sel", 32'(Alu_Select), 32'd0);
    for (int r = 0; r < 8; r++) begin
      rd_reg(3'(r), rd_val);
      chk($sformatf("abort.r%0d", r), rd_val, 32'd0);
    end
    @(negedge Clk);
    Rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge Clk); #1;
      chk($sformatf("abort.post%0d", c), 32'({Done, Err, Instr_Ready}), 32'b001);
    end
    rd_reg(3'd1, rd_val); chk("abort.r1_after", rd_val, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
